// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store initiator for the word-addressed data memory
// Byte/half stores are read-modify-write; misaligned or out-of-range requests raise exc without touching memory.
module mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_pc,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, EXC} stateT;

  localparam logic [ADDR_W-3:0] DmLimit = (ADDR_W-2)'(DM_WORDS);

  stateT             state;
  logic              weQ;
  logic [1:0]        sizeQ;
  logic              unsignedQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic [31:0]       pcQ;
  logic [31:0]       mergeQ;

  logic              reqErr;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       loadVal;
  logic [31:0]       mergeWord;

  always_comb begin
    reqErr = (req_size == 2'b11)
          || (req_size == 2'b01 && req_addr[0])
          || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
          || (req_addr[ADDR_W-1:2] >= DmLimit);
  end

  // Lane extraction for loads and lane replacement for sub-word stores share the latched address.
  always_comb begin
    byteSel   = mem_rdata[{addrQ[1:0], 3'b000} +: 8];
    halfSel   = mem_rdata[{addrQ[1], 4'b0000} +: 16];
    mergeWord = mem_rdata;
    case (sizeQ)
      2'b00:   loadVal = unsignedQ ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadVal = unsignedQ ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadVal = mem_rdata;
    endcase
    if (sizeQ == 2'b00) begin
      mergeWord[{addrQ[1:0], 3'b000} +: 8] = wdataQ[7:0];
    end else begin
      mergeWord[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= '0;
      weQ       <= 1'b0;
      sizeQ     <= '0;
      unsignedQ <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      pcQ       <= '0;
      mergeQ    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weQ       <= req_we;
            sizeQ     <= req_size;
            unsignedQ <= req_unsigned;
            addrQ     <= req_addr;
            wdataQ    <= req_wdata;
            pcQ       <= req_pc;
            if (reqErr)
              state <= EXC;
            else if (req_we && req_size == 2'b10)
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          if (weQ) begin
            mergeQ <= mergeWord;
            state  <= WR;
          end else begin
            rdata <= loadVal;
            state <= DONE;
          end
        end
        WR:      state <= DONE;
        DONE:    state <= IDLE;
        EXC:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // mem_we is gated by reset so a reset landing on the write cycle leaves memory untouched.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign exc       = (state == EXC);
  assign mem_we    = (state == WR) && !reset;
  assign mem_wdata = (sizeQ == 2'b10) ? wdataQ : mergeQ;
  assign mem_addr  = {addrQ[ADDR_W-1:2], 2'b00};
  assign mem_pc    = pcQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
// Directed table from the access rules, hand sequences for reset/hold corners, then random requests against a reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        exc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;

  mem_access_ctrl #(.ADDR_W(32), .DM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .busy(busy), .done(done), .rdata(rdata), .exc(exc), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initVal(input int i);
    if (i == 4) return 32'h8899AABB;
    if (i == 5) return 32'h0;
    if (i == 1023) return 32'h5A5A1234;
    return (32'(i) * 32'h9E3779B9) ^ 32'h13572468;
  endfunction

  logic        tbInit;
  logic [31:0] mem [0:1023];
  logic [31:0] refMem [0:1023];

  always @(posedge clk) begin
    if (tbInit) begin
      for (int i = 0; i < 1024; i++) mem[i] <= initVal(i);
    end else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  int total = 0;
  int bad = 0;
  logic [31:0] lastRdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic modelErr(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= 1024);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [31:0] addr);
    int sh;
    logic [31:0] v;
    sh = 8 * int'(addr % 4);
    if (size == 2'd2) return word;
    if (size == 2'd0) begin
      v = (word >> sh) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else begin
      v = (word >> sh) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] word, input logic [1:0] size,
                                             input logic [31:0] addr, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (size == 2'd2) return wd;
    sh = 8 * int'(addr % 4);
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expExc;
    int          expLat;
    logic [31:0] expRdata;
    logic [31:0] expWord;
  } vecT;

  // Issues one request, holding it (with scrambled payload) until done/exc, and reports what was seen.
  task automatic doReq(input vecT v, input logic [31:0] pc, output int lat, output logic sawExc,
                       output int weCnt, output logic addrOk, output logic pcOk);
    logic fin;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_pc = pc; req_valid = 1'b1;
    lat = 0; weCnt = 0; sawExc = 1'b0; addrOk = 1'b1; pcOk = 1'b1; fin = 1'b0;
    while (!fin && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_we) weCnt++;
      if (mem_pc !== pc) pcOk = 1'b0;
      if (mem_addr !== {v.addr[31:2], 2'b00}) addrOk = 1'b0;
      if (done || exc) begin
        fin = 1'b1;
        sawExc = exc;
      end else begin
        req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic runAndCheck(input vecT v, input string tag);
    int lat, weCnt;
    logic sawExc, addrOk, pcOk;
    logic [31:0] expRd;
    logic [9:0] idx;
    doReq(v, $urandom, lat, sawExc, weCnt, addrOk, pcOk);
    expRd = (!v.we && !v.expExc) ? v.expRdata : lastRdata;
    check({tag, " exc"}, 32'(sawExc), 32'(v.expExc));
    check({tag, " latency"}, 32'(lat), 32'(v.expLat));
    check({tag, " mem_we cycles"}, 32'(weCnt), (v.we && !v.expExc) ? 32'd1 : 32'd0);
    check({tag, " rdata"}, rdata, expRd);
    check({tag, " mem_addr"}, 32'(addrOk), 32'd1);
    check({tag, " mem_pc"}, 32'(pcOk), 32'd1);
    @(negedge clk);
    check({tag, " idle after"}, {29'b0, busy, done, exc}, 32'd0);
    idx = v.addr[11:2];
    if (v.we && !v.expExc) begin
      refMem[idx] = modelStore(refMem[idx], v.size, v.addr, v.wdata);
      check({tag, " stored word"}, mem[idx], v.expWord);
    end
    lastRdata = expRd;
  endtask

  vecT tab [17];

  initial begin
    int weCnt, doneCnt;
    vecT v;
    logic err;
    logic [31:0] holdWord;

    tab[0]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        1'b0, 2, 32'hFFFFFFAA, 32'h0};
    tab[1]  = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        1'b0, 2, 32'h000000AA, 32'h0};
    tab[2]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        1'b0, 2, 32'hFFFF8899, 32'h0};
    tab[3]  = '{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        1'b0, 2, 32'h0000AABB, 32'h0};
    tab[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 2, 32'h8899AABB, 32'h0};
    tab[5]  = '{1'b1, 2'd0, 1'b0, 32'h13,   32'h123456CC, 1'b0, 3, 32'h0,        32'hCC99AABB};
    tab[6]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 2, 32'hCC99AABB, 32'h0};
    tab[7]  = '{1'b1, 2'd1, 1'b0, 32'h16,   32'h0000BEEF, 1'b0, 3, 32'h0,        32'hBEEF0000};
    tab[8]  = '{1'b1, 2'd2, 1'b0, 32'h18,   32'hDEADBEEF, 1'b0, 2, 32'h0,        32'hDEADBEEF};
    tab[9]  = '{1'b0, 2'd2, 1'b0, 32'h18,   32'h0,        1'b0, 2, 32'hDEADBEEF, 32'h0};
    tab[10] = '{1'b0, 2'd2, 1'b0, 32'h02,   32'h0,        1'b1, 1, 32'h0,        32'h0};
    tab[11] = '{1'b0, 2'd1, 1'b0, 32'h01,   32'h0,        1'b1, 1, 32'h0,        32'h0};
    tab[12] = '{1'b0, 2'd3, 1'b0, 32'h20,   32'h0,        1'b1, 1, 32'h0,        32'h0};
    tab[13] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        1'b1, 1, 32'h0,        32'h0};
    tab[14] = '{1'b0, 2'd2, 1'b0, 32'hFFC,  32'h0,        1'b0, 2, 32'h5A5A1234, 32'h0};
    tab[15] = '{1'b0, 2'd0, 1'b0, 32'hFFF,  32'h0,        1'b0, 2, 32'h0000005A, 32'h0};
    tab[16] = '{1'b1, 2'd1, 1'b0, 32'h15,   32'h0000FFFF, 1'b1, 1, 32'h0,        32'h0};

    for (int i = 0; i < 1024; i++) refMem[i] = initVal(i);
    reset = 1'b1; tbInit = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset exc", 32'(exc), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    tbInit = 1'b0; reset = 1'b0;

    for (int i = 0; i < 17; i++) runAndCheck(tab[i], $sformatf("vec%0d", i));

    // Reset landing on the write cycle of a byte store must abandon it silently.
    holdWord = mem[8];
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h21;
    req_wdata = 32'h77; req_pc = 32'h400; req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstwr in WR", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rstwr mem_we gated", 32'(mem_we), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rstwr idle", {29'b0, busy, done, exc}, 32'd0);
    check("rstwr word kept", mem[8], holdWord);
    check("rstwr rdata cleared", rdata, 32'd0);
    lastRdata = 32'h0;

    // Request still held through the DONE cycle must not be taken a second time.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h24; req_wdata = 32'hA5A5F00D;
    req_pc = 32'h500; req_valid = 1'b1;
    weCnt = 0; doneCnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) weCnt++;
      if (done) doneCnt++;
    end
    check("hold busy after done", 32'(busy), 32'd0);
    req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (mem_we) weCnt++;
      if (done) doneCnt++;
    end
    check("hold mem_we count", 32'(weCnt), 32'd1);
    check("hold done count", 32'(doneCnt), 32'd1);
    refMem[9] = 32'hA5A5F00D;
    check("hold stored word", mem[9], 32'hA5A5F00D);

    for (int n = 0; n < 250; n++) begin
      v.we  = 1'($urandom_range(0, 1));
      v.uns = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2: v.size = 2'd0;
        3, 4, 5: v.size = 2'd1;
        6, 7, 8: v.size = 2'd2;
        default: v.size = 2'd3;
      endcase
      v.addr  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(32'hFF0, 32'h100F))
                                            : 32'($urandom_range(0, 63));
      v.wdata = $urandom;
      err = modelErr(v.size, v.addr);
      v.expExc = err;
      v.expLat = err ? 1 : ((!v.we || v.size == 2'd2) ? 2 : 3);
      v.expRdata = modelLoad(refMem[v.addr[11:2]], v.size, v.uns, v.addr);
      v.expWord = modelStore(refMem[v.addr[11:2]], v.size, v.addr, v.wdata);
      runAndCheck(v, $sformatf("rnd%0d", n));
    end

    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== refMem[i]) check($sformatf("final word %0d", i), mem[i], refMem[i]);
    end
    check("final word 4", mem[4], refMem[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
